// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front-end: key codes, the scan-position
// to key-code map, the debounce FSM states and the stopwatch mode value.
package keypad_pkg;

    localparam logic [3:0] KEY_A = 4'd10;
    localparam logic [3:0] KEY_B = 4'd11;
    localparam logic [3:0] KEY_C = 4'd12;
    localparam logic [3:0] KEY_D = 4'd13;

    localparam logic [3:0] MODE_STOPWATCH = 4'd0;

    // Nibble i holds the code for row i/4, column i%4 (row0 in the low nibbles):
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
    localparam logic [63:0] KEY_MAP = {
        4'd13, 4'd15, 4'd0,  4'd14,
        4'd12, 4'd9,  4'd8,  4'd7,
        4'd11, 4'd6,  4'd5,  4'd4,
        4'd10, 4'd3,  4'd2,  4'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_HELD,
        ST_REL
    } kp_state_e;

    // Look up the key code at a given row/column scan position.
    function automatic logic [3:0] key_map_code(input logic [1:0] row, input logic [1:0] col);
        logic [5:0] base;
        base = {row, col, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/key_scan_frame.sv
// Keypad scanner: synchronises the columns, rotates the active-low row drive,
// latches the first pressed key of each 4-row frame and flags the frame end.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   key_col_i[3:0]       raw active-low columns (asynchronous)
//   key_row_o[3:0]       one-hot active-low row drive
//   frame_end_c_o        high in the last cycle of the row3 slot
//   frame_valid_c_o      at least one key seen in this frame (valid at frame end)
//   frame_code_c_o       first key in scan order for this frame
module key_scan_frame
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] key_col_i,
    output logic [3:0] key_row_o,
    output logic       frame_end_c_o,
    output logic       frame_valid_c_o,
    output logic [3:0] frame_code_c_o
);

    localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]        col_meta_q, col_sync_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        row_drv_q, row_drv_d;
    logic              hit_q, hit_d;
    logic [3:0]        code_q, code_d;
    logic              slot_last, frame_end, row_hit;
    logic [3:0]        row_code;

    // Two-flop synchroniser; idle columns read high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= key_col_i;
            col_sync_q <= col_meta_q;
        end
    end

    // Lowest pressed column in the active row wins (loop runs high to low).
    always_comb begin
        row_hit  = 1'b0;
        row_code = 4'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync_q[c]) begin
                row_hit  = 1'b1;
                row_code = key_map_code(row_q, 2'(c));
            end
        end
    end

    // Slot counting, row rotation and first-hit latch.
    always_comb begin
        slot_last = (slot_q == SLOT_LAST);
        frame_end = slot_last && (row_q == 2'd3);
        slot_d    = slot_last ? '0 : slot_q + SLOT_W'(1);
        row_d     = row_q;
        row_drv_d = row_drv_q;
        hit_d     = hit_q;
        code_d    = code_q;
        if (slot_last) begin
            row_d     = row_q + 2'd1;
            row_drv_d = ~(4'b0001 << row_d);
            if (frame_end) begin
                hit_d  = 1'b0;
                code_d = 4'd0;
            end else if (!hit_q && row_hit) begin
                hit_d  = 1'b1;
                code_d = row_code;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            row_q     <= 2'd0;
            row_drv_q <= 4'b1110;
            hit_q     <= 1'b0;
            code_q    <= 4'd0;
        end else begin
            slot_q    <= slot_d;
            row_q     <= row_d;
            row_drv_q <= row_drv_d;
            hit_q     <= hit_d;
            code_q    <= code_d;
        end
    end

    // Row3's own sample is merged in so the frame result is complete at frame end.
    assign key_row_o       = row_drv_q;
    assign frame_end_c_o   = frame_end;
    assign frame_valid_c_o = hit_q | row_hit;
    assign frame_code_c_o  = hit_q ? code_q : row_code;

endmodule

// File: rtl/keypad_ctrl.sv
// Keypad front-end: frame-level debounce FSM producing one-cycle key pulses,
// A/B character strobes and the shared MODE register.
// Ports:
//   CLK, RESET       clock, async active-low reset
//   KEY_COL[3:0]     keypad columns, active-low, asynchronous
//   KEY_ROW[3:0]     row drive, one-hot active-low
//   CHAR_SYNC[1:0]   [0] key A pulse, [1] key B pulse
//   MODE[3:0]        current mode, wraps modulo NUM_MODES
//   KEY_PRESS        one-cycle pulse per accepted press
//   KEY_CODE[3:0]    code of the last accepted key
module keypad_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 250,
    parameter int unsigned DEBOUNCE  = 4,
    parameter int unsigned NUM_MODES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_COL,
    output logic [3:0] KEY_ROW,
    output logic [1:0] CHAR_SYNC,
    output logic [3:0] MODE,
    output logic       KEY_PRESS,
    output logic [3:0] KEY_CODE
);

    localparam logic [3:0] DEB      = 4'(DEBOUNCE);
    localparam logic [3:0] MODE_MAX = 4'(NUM_MODES - 1);

    logic       frame_end, frame_valid;
    logic [3:0] frame_code;

    kp_state_e  state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic       key_press_q, key_press_d;
    logic [3:0] key_code_q, key_code_d;
    logic [1:0] char_sync_q, char_sync_d;
    logic [3:0] mode_q, mode_d;
    logic       accept;

    key_scan_frame #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_i           (CLK),
        .rst_ni          (RESET),
        .key_col_i       (KEY_COL),
        .key_row_o       (KEY_ROW),
        .frame_end_c_o   (frame_end),
        .frame_valid_c_o (frame_valid),
        .frame_code_c_o  (frame_code)
    );

    // Debounce FSM, stepped once per frame; accept drives the output pulses.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_press_d = 1'b0;
        key_code_d  = key_code_q;
        char_sync_d = 2'b00;
        mode_d      = mode_q;
        accept      = 1'b0;
        cnt_inc     = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_valid) begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                        if (DEB <= 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (!frame_valid) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else if (frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end
                end
                ST_HELD: begin
                    if (!frame_valid) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB <= 4'd1) ? ST_IDLE : ST_REL;
                    end
                end
                ST_REL: begin
                    if (frame_valid) begin
                        state_d = ST_HELD;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DEB) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        if (accept) begin
            key_press_d = 1'b1;
            key_code_d  = cand_d;
            case (cand_d)
                KEY_A:   char_sync_d = 2'b01;
                KEY_B:   char_sync_d = 2'b10;
                KEY_C:   mode_d = (mode_q >= MODE_MAX) ? MODE_STOPWATCH : mode_q + 4'd1;
                KEY_D:   mode_d = MODE_STOPWATCH;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= 4'd0;
            key_press_q <= 1'b0;
            key_code_q  <= 4'd0;
            char_sync_q <= 2'b00;
            mode_q      <= MODE_STOPWATCH;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_press_q <= key_press_d;
            key_code_q  <= key_code_d;
            char_sync_q <= char_sync_d;
            mode_q      <= mode_d;
        end
    end

    assign KEY_PRESS = key_press_q;
    assign KEY_CODE  = key_code_q;
    assign CHAR_SYNC = char_sync_q;
    assign MODE      = mode_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// Bench for keypad_ctrl: a keypad matrix model drives the columns from the
// row drive; each frame's key set feeds a run-length debounce model whose
// predicted pulses are queued and checked by an independent monitor.
module tb_keypad_ctrl;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned DEBOUNCE  = 3;
    localparam int unsigned NUM_MODES = 4;
    localparam int          FRAME     = 4 * SCAN_DIV;

    localparam logic [15:0] K_A = 16'h0008;
    localparam logic [15:0] K_B = 16'h0080;
    localparam logic [15:0] K_C = 16'h0800;
    localparam logic [15:0] K_D = 16'h8000;
    localparam logic [15:0] K_NONE = 16'h0000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] KEY_COL;
    logic [3:0] KEY_ROW;
    logic [1:0] CHAR_SYNC;
    logic [3:0] MODE;
    logic       KEY_PRESS;
    logic [3:0] KEY_CODE;

    logic [15:0] keys = '0;
    int n_pass = 0;
    int n_chk  = 0;
    int cyc;

    typedef struct {
        int       code;
        logic [1:0] cs;
        int       mode;
        int       at;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (run lengths of identical frames).
    string layout = "123A456B789C*0#D";
    bit armed;
    int inv_run, val_run, last_code, m_mode, m_code, fidx;

    keypad_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .DEBOUNCE  (DEBOUNCE),
        .NUM_MODES (NUM_MODES)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .KEY_COL   (KEY_COL),
        .KEY_ROW   (KEY_ROW),
        .CHAR_SYNC (CHAR_SYNC),
        .MODE      (MODE),
        .KEY_PRESS (KEY_PRESS),
        .KEY_CODE  (KEY_CODE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        KEY_COL = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!KEY_ROW[r])
                for (int c = 0; c < 4; c++)
                    if (keys[r*4 + c]) KEY_COL[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic int code_of(input byte ch);
        case (ch)
            "A": return 10;
            "B": return 11;
            "C": return 12;
            "D": return 13;
            "*": return 14;
            "#": return 15;
            default: return int'(ch) - 48;
        endcase
    endfunction

    task automatic model_reset();
        armed     = 1'b1;
        inv_run   = 0;
        val_run   = 0;
        last_code = -1;
        m_mode    = 0;
        m_code    = 0;
        fidx      = 0;
    endtask

    // One frame: a press is accepted after DEBOUNCE identical valid frames,
    // and re-arms only after DEBOUNCE consecutive empty frames.
    task automatic model_frame(input logic [15:0] s);
        int code;
        exp_t e;
        code = -1;
        for (int i = 0; i < 16; i++)
            if (s[i] && code < 0) code = code_of(layout[i]);
        fidx++;
        if (code < 0) begin
            inv_run++;
            val_run   = 0;
            last_code = -1;
            if (inv_run >= int'(DEBOUNCE)) armed = 1'b1;
        end else begin
            inv_run   = 0;
            val_run   = (code == last_code) ? val_run + 1 : 1;
            last_code = code;
            if (armed && val_run == int'(DEBOUNCE)) begin
                armed  = 1'b0;
                m_code = code;
                if (code == 12) m_mode = (m_mode + 1) % int'(NUM_MODES);
                if (code == 13) m_mode = 0;
                e.code = code;
                e.cs   = (code == 10) ? 2'b01 : (code == 11) ? 2'b10 : 2'b00;
                e.mode = m_mode;
                e.at   = fidx * FRAME;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_frames(input logic [15:0] s, input int n);
        repeat (n) begin
            keys = s;
            model_frame(s);
            repeat (FRAME) @(posedge CLK);
            @(negedge CLK);
            check("key_code_hold", int'(KEY_CODE), m_code);
            check("mode_hold", int'(MODE), m_mode);
        end
    endtask

    task automatic press(input logic [15:0] s);
        run_frames(s, 5);
        run_frames(K_NONE, 5);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_row"}, int'(KEY_ROW), 14);
        check({tag, "_char_sync"}, int'(CHAR_SYNC), 0);
        check({tag, "_mode"}, int'(MODE), 0);
        check({tag, "_key_press"}, int'(KEY_PRESS), 0);
        check({tag, "_key_code"}, int'(KEY_CODE), 0);
    endtask

    // Monitor: every accepted press must match the next queued expectation.
    always @(negedge CLK) begin
        if (RESET) begin
            if (KEY_PRESS) begin
                check("press_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("press_code", int'(KEY_CODE), e.code);
                    check("press_char_sync", int'(CHAR_SYNC), int'(e.cs));
                    check("press_mode", int'(MODE), e.mode);
                    check("press_cycle", cyc, e.at);
                end
            end else begin
                check("char_sync_without_press", int'(CHAR_SYNC), 0);
            end
        end
    end

    initial begin
        logic [15:0] s;
        int sel, hold;

        model_reset();
        RESET = 1'b0;
        keys  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_values("reset");
        RESET = 1'b1;

        // Long hold of A: one pulse only.
        run_frames(K_A, 10);
        run_frames(K_NONE, 4);

        // B bouncing every frame: never accepted.
        repeat (6) begin
            run_frames(K_B, 1);
            run_frames(K_NONE, 1);
        end
        run_frames(K_NONE, 3);

        // Mode stepping with C, wrap, then D from MODE=2.
        repeat (4) press(K_C);
        press(K_C);
        press(K_C);
        press(K_D);

        // A and B together; B must not fire until a full release.
        run_frames(K_A | K_B, 6);
        run_frames(K_B, 6);
        run_frames(K_NONE, 3);
        run_frames(K_B, 5);
        run_frames(K_NONE, 4);

        // Short release is absorbed, full release re-arms.
        run_frames(K_A, 5);
        run_frames(K_NONE, 2);
        run_frames(K_A, 5);
        run_frames(K_NONE, 3);
        run_frames(K_A, 5);
        run_frames(K_NONE, 4);

        // Reset mid-candidate with MODE=2.
        press(K_C);
        press(K_C);
        run_frames(K_C, 1);
        repeat (5) @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        run_frames(K_C, 5);
        run_frames(K_NONE, 4);

        // Random key sets and hold times.
        repeat (40) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: s = K_NONE;
                1: s = 16'(1) << $urandom_range(0, 15);
                2: s = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                default: s = ($urandom_range(0, 1) == 0) ? K_C : K_D;
            endcase
            hold = int'($urandom_range(1, 6));
            run_frames(s, hold);
        end
        run_frames(K_NONE, 4);

        @(negedge CLK);
        check("expected_queue_empty", int'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
